// File: rtl/vga_stream_pkg.sv
// vga_stream_pkg: shared types and defaults for the stream-to-VGA sink.
//   sink_state_t  - lock state of the sink (SYNC hunting for sof, RUN displaying)
//   pix_entry_t   - FIFO entry {sof, pix} at the default 8-bit pixel width
//   *_DEF         - default raster size, FIFO depth and fill pixel
//   is_pow2       - helper for parameter checks
package vga_stream_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } sink_state_t;

    localparam int PIX_W_DEF    = 8;
    localparam int DEPTH_DEF    = 16;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam logic [PIX_W_DEF-1:0] FILL_PIX_DEF = 8'd0;

    typedef struct packed {
        logic                 sof;
        logic [PIX_W_DEF-1:0] pix;
    } pix_entry_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head.
//   clk, reset - clock and synchronous active-high reset (empties the FIFO)
//   push/wdata - write request; ignored when full (judged on the registered count)
//   pop        - read request; ignored when empty
//   rdata      - current head entry, valid whenever empty is low
//   full/empty - status decoded from the registered occupancy count
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/stream_vga_sink.sv
// stream_vga_sink: schedules a valid/ready grayscale pixel stream onto a VGA raster.
//   clk, reset          - pixel clock, synchronous active-high reset
//   pix_in, sof_in,
//   valid_in            - upstream pixel, start-of-frame flag and valid
//   output_ready        - ready to upstream (FIFO not full, low during reset)
//   hcount, vcount,
//   visible             - raster position and active-area flag from vga_sync
//   vga_pix, vga_valid  - registered pixel for the DAC; valid low on fill
//   locked              - sink is in RUN
//   sync_lost           - one-cycle pulse when RUN is left on an error
//   underrun_count      - saturating count of fill pixels inserted while locked
module stream_vga_sink
    import vga_stream_pkg::*;
#(
    parameter int               PIX_W    = PIX_W_DEF,
    parameter int               DEPTH    = DEPTH_DEF,
    parameter int               H_ACTIVE = H_ACTIVE_DEF,
    parameter int               V_ACTIVE = V_ACTIVE_DEF,
    parameter logic [PIX_W-1:0] FILL_PIX = PIX_W'(FILL_PIX_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             sof_in,
    input  logic             valid_in,
    output logic             output_ready,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    input  logic             visible,
    output logic [PIX_W-1:0] vga_pix,
    output logic             vga_valid,
    output logic             locked,
    output logic             sync_lost,
    output logic [15:0]      underrun_count
);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("stream_vga_sink: DEPTH must be a power of two and at least 4");
    end
    if (H_ACTIVE < 1 || H_ACTIVE > 1024 || V_ACTIVE < 1 || V_ACTIVE > 1024) begin : g_bad_raster
        $error("stream_vga_sink: active area must fit the 10-bit raster counters");
    end

    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] pix;
    } entry_t;

    sink_state_t      state;
    sink_state_t      state_n;
    entry_t           wr_entry;
    entry_t           head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             at_origin;
    logic [PIX_W-1:0] pix_n;
    logic             valid_n;
    logic             lost_n;
    logic             underrun;

    // Ready depends only on registered state, never on valid_in.
    assign output_ready = !reset && !full;
    assign push         = valid_in && output_ready;
    assign wr_entry     = '{sof: sof_in, pix: pix_in};
    assign at_origin    = visible && (hcount == '0) && (vcount == '0);
    assign locked       = (state == RUN);

    sync_fifo #(
        .WIDTH (PIX_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        pix_n    = FILL_PIX;
        valid_n  = 1'b0;
        lost_n   = 1'b0;
        underrun = 1'b0;
        if (state == SYNC) begin
            if (!empty && !head.sof) begin
                pop = 1'b1;
            end else if (!empty && at_origin) begin
                pop     = 1'b1;
                pix_n   = head.pix;
                valid_n = 1'b1;
                state_n = RUN;
            end
        end else if (visible) begin
            // A frame boundary must coincide with raster origin; any
            // disagreement between head sof and (0,0) means lost lock.
            if (empty) begin
                underrun = 1'b1;
            end else if (head.sof != at_origin) begin
                lost_n  = 1'b1;
                state_n = SYNC;
            end else begin
                pop     = 1'b1;
                pix_n   = head.pix;
                valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= SYNC;
            vga_pix        <= FILL_PIX;
            vga_valid      <= 1'b0;
            sync_lost      <= 1'b0;
            underrun_count <= '0;
        end else begin
            state     <= state_n;
            vga_pix   <= pix_n;
            vga_valid <= valid_n;
            sync_lost <= lost_n;
            if (underrun && underrun_count != 16'hFFFF) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stream_vga_sink.sv
// tb_stream_vga_sink: directed bench for stream_vga_sink on a 4x2 raster, DEPTH=4.
module tb_stream_vga_sink;

    logic        clk;
    logic        reset;
    logic [7:0]  pix_in;
    logic        sof_in;
    logic        valid_in;
    logic        output_ready;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        visible;
    logic [7:0]  vga_pix;
    logic        vga_valid;
    logic        locked;
    logic        sync_lost;
    logic [15:0] underrun_count;

    int errors;
    int checks;

    logic [8:0] src[$];
    logic [7:0] ep[8];
    logic       ev[8];
    logic       el[8];
    logic       es[8];
    logic       rdy_log[8];
    int         sz_log[8];

    stream_vga_sink #(
        .PIX_W    (8),
        .DEPTH    (4),
        .H_ACTIVE (4),
        .V_ACTIVE (2),
        .FILL_PIX (8'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pix_in         (pix_in),
        .sof_in         (sof_in),
        .valid_in       (valid_in),
        .output_ready   (output_ready),
        .hcount         (hcount),
        .vcount         (vcount),
        .visible        (visible),
        .vga_pix        (vga_pix),
        .vga_valid      (vga_valid),
        .locked         (locked),
        .sync_lost      (sync_lost),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vis, input logic [9:0] h, input logic [9:0] v);
        logic acc;
        visible  = vis;
        hcount   = h;
        vcount   = v;
        valid_in = (src.size() > 0);
        {sof_in, pix_in} = valid_in ? src[0] : 9'd0;
        acc = valid_in && output_ready;
        @(posedge clk);
        #1;
        if (acc) void'(src.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'd4, 10'd2);
    endtask

    task automatic set_exp(input int base, input int nval, input int nlock, input int lost_at);
        for (int i = 0; i < 8; i++) begin
            ep[i] = (i < nval) ? 8'(base + i) : 8'd0;
            ev[i] = (i < nval);
            el[i] = (i < nlock);
            es[i] = (i == lost_at);
        end
    endtask

    task automatic frame(input string tag);
        int k;
        k = 0;
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < 6; h++) begin
                step(h < 4, 10'(h), 10'(v));
                if (h < 4) begin
                    chk($sformatf("%s_c%0d_pix", tag, k), 16'(vga_pix), 16'(ep[k]));
                    chk($sformatf("%s_c%0d_valid", tag, k), 16'(vga_valid), 16'(ev[k]));
                    chk($sformatf("%s_c%0d_locked", tag, k), 16'(locked), 16'(el[k]));
                    chk($sformatf("%s_c%0d_lost", tag, k), 16'(sync_lost), 16'(es[k]));
                    rdy_log[k] = output_ready;
                    sz_log[k]  = src.size();
                    k++;
                end else begin
                    chk($sformatf("%s_hb%0d_valid", tag, v), 16'(vga_valid), 16'd0);
                    chk($sformatf("%s_hb%0d_pix", tag, v), 16'(vga_pix), 16'd0);
                end
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 10'(i), 10'd2);
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        errors   = 0;
        checks   = 0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        pix_in   = 8'd0;
        visible  = 1'b0;
        hcount   = 10'd0;
        vcount   = 10'd0;

        // Reset and idle state.
        step(1'b0, 10'd0, 10'd0);
        step(1'b0, 10'd0, 10'd0);
        chk("ready_in_reset", 16'(output_ready), 16'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 16'(output_ready), 16'd1);
        chk("reset_pix", 16'(vga_pix), 16'd0);
        chk("reset_valid", 16'(vga_valid), 16'd0);
        chk("reset_locked", 16'(locked), 16'd0);
        chk("reset_lost", 16'(sync_lost), 16'd0);
        chk("reset_underrun", underrun_count, 16'd0);

        // Idle raster with pre-sof garbage: discarded, never locks.
        src = '{9'h091, 9'h092, 9'h093};
        set_exp(0, 0, 0, -1);
        frame("idle");
        chk("idle_underrun", underrun_count, 16'd0);
        chk("idle_ready", 16'(output_ready), 16'd1);

        // Preload 1..8 with sof on 1; FIFO fills after 4 pushes.
        src = '{9'h101, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007, 9'h008};
        idle(6);
        chk("preload_ready_low", 16'(output_ready), 16'd0);
        chk("preload_held", 16'(src.size()), 16'd4);
        set_exp(1, 8, 8, -1);
        frame("f2");
        chk("f2_ready_after_pop", 16'(rdy_log[0]), 16'd1);
        chk("f2_fifth_accepted", 16'(sz_log[1]), 16'd3);
        chk("f2_underrun", underrun_count, 16'd0);

        // Short frame: 6 of 8 pixels, two fill slots.
        src = '{9'h111, 9'h012, 9'h013, 9'h014, 9'h015, 9'h016};
        idle(6);
        set_exp(8'h11, 6, 8, -1);
        frame("f3");
        chk("f3_underrun", underrun_count, 16'd2);
        chk("f3_locked", 16'(locked), 16'd1);

        // sof injected on the 3rd pixel: lose lock, relock on it next frame.
        src = '{9'h121, 9'h022, 9'h123, 9'h024, 9'h025, 9'h026, 9'h027, 9'h028, 9'h029, 9'h030};
        idle(6);
        set_exp(8'h21, 2, 2, 2);
        frame("f4");
        chk("f4_underrun", underrun_count, 16'd2);
        set_exp(8'h23, 8, 8, -1);
        ep[7] = 8'h30;
        ep[6] = 8'h29;
        frame("f5");
        chk("f5_underrun", underrun_count, 16'd2);

        // Reset mid-frame with 3 entries buffered.
        src = '{9'h161, 9'h062, 9'h063, 9'h064};
        idle(6);
        step(1'b1, 10'd0, 10'd0);
        chk("f6_pix", 16'(vga_pix), 16'h61);
        chk("f6_locked", 16'(locked), 16'd1);
        reset = 1'b1;
        step(1'b1, 10'd1, 10'd0);
        chk("mid_reset_ready", 16'(output_ready), 16'd0);
        chk("mid_reset_pix", 16'(vga_pix), 16'd0);
        chk("mid_reset_valid", 16'(vga_valid), 16'd0);
        chk("mid_reset_locked", 16'(locked), 16'd0);
        chk("mid_reset_lost", 16'(sync_lost), 16'd0);
        chk("mid_reset_underrun", underrun_count, 16'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", 16'(output_ready), 16'd1);

        // FIFO must be empty: exactly 4 more pushes fit.
        src = '{9'h171, 9'h172, 9'h173, 9'h174};
        idle(3);
        chk("post_reset_3push_ready", 16'(output_ready), 16'd1);
        idle(1);
        chk("post_reset_4push_ready", 16'(output_ready), 16'd0);
        chk("post_reset_src_empty", 16'(src.size()), 16'd0);
        step(1'b1, 10'd0, 10'd0);
        chk("relock_pix", 16'(vga_pix), 16'h71);
        chk("relock_valid", 16'(vga_valid), 16'd1);
        chk("relock_locked", 16'(locked), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
